// File: rtl/id_ex_stage_pkg.sv
// Shared constants and types for the ID/EX stage: forwarding selects,
// ALU op codes and the control bundle loaded on a bubble.
package id_ex_stage_pkg;

  // Forwarding select encodings driven by the hazard unit
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // ALU op codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  // Decoded controls carried through the E register
  typedef struct packed {
    logic [2:0] alu_ctrl;
    logic       alu_src;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
  } ctrl_t;

  // A bubble is a harmless add with no side effects downstream
  localparam ctrl_t BUBBLE_CTRL = '{ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/id_ex_stage_fwd_mux3.sv
// Parameterised 3:1 forwarding mux; the reserved select 2'b11 falls back
// to the register value.
module fwd_mux3
  import id_ex_stage_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] reg_val,
  input  logic [W-1:0] wb_val,
  input  logic [W-1:0] mem_val,
  output logic [W-1:0] y
);

  // Select operand source from the hazard unit's choice
  always_comb begin
    y = reg_val;
    case (sel)
      FWD_WB:  y = wb_val;
      FWD_MEM: y = mem_val;
      default: y = reg_val;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register plus execute-side operand selection.
// Optional: define ID_EX_BUBBLE_CNT_EN to add a saturating BubbleCountE
// counter of flush (bubble) cycles.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int data_size  = 32,
  parameter int reg_addr_w = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  StallE,
  input  logic                  FlushE,
  input  logic [data_size-1:0]  RD1D,
  input  logic [data_size-1:0]  RD2D,
  input  logic [data_size-1:0]  SignImmD,
  input  logic [reg_addr_w-1:0] RsD,
  input  logic [reg_addr_w-1:0] RtD,
  input  logic [reg_addr_w-1:0] RdD,
  input  logic [2:0]            ALUControlD,
  input  logic                  ALUSrcD,
  input  logic                  RegDstD,
  input  logic                  RegWriteD,
  input  logic                  MemtoRegD,
  input  logic                  MemWriteD,
  input  logic [1:0]            ForwardAE,
  input  logic [1:0]            ForwardBE,
  input  logic [data_size-1:0]  ALUOutM,
  input  logic [data_size-1:0]  ResultW,
  output logic [data_size-1:0]  SrcAE,
  output logic [data_size-1:0]  SrcBE,
  output logic [2:0]            ALUControlE,
  output logic [data_size-1:0]  WriteDataE,
  output logic [reg_addr_w-1:0] WriteRegE,
  output logic [reg_addr_w-1:0] RsE,
  output logic [reg_addr_w-1:0] RtE,
  output logic                  RegWriteE,
  output logic                  MemtoRegE,
`ifdef ID_EX_BUBBLE_CNT_EN
  output logic                  MemWriteE,
  output logic [31:0]           BubbleCountE
`else
  output logic                  MemWriteE
`endif
);

  logic [data_size-1:0]  rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q;
  logic [reg_addr_w-1:0] rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
  ctrl_t                 ctrl_d, ctrl_q;
  logic [data_size-1:0]  fwd_a, fwd_b;

  // Next-state: flush beats stall, stall holds, otherwise load from D
  always_comb begin
    rd1_d  = rd1_q;
    rd2_d  = rd2_q;
    imm_d  = imm_q;
    rs_d   = rs_q;
    rt_d   = rt_q;
    rd_d   = rd_q;
    ctrl_d = ctrl_q;
    if (FlushE) begin
      rd1_d  = '0;
      rd2_d  = '0;
      imm_d  = '0;
      rs_d   = '0;
      rt_d   = '0;
      rd_d   = '0;
      ctrl_d = BUBBLE_CTRL;
    end else if (!StallE) begin
      rd1_d  = RD1D;
      rd2_d  = RD2D;
      imm_d  = SignImmD;
      rs_d   = RsD;
      rt_d   = RtD;
      rd_d   = RdD;
      ctrl_d = '{ALUControlD, ALUSrcD, RegDstD, RegWriteD, MemtoRegD, MemWriteD};
    end
  end

  // E registers; reset loads the same bubble as a flush
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
      ctrl_q <= BUBBLE_CTRL;
    end else begin
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      imm_q  <= imm_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
      rd_q   <= rd_d;
      ctrl_q <= ctrl_d;
    end
  end

  fwd_mux3 #(.W(data_size)) u_fwd_a (
    .sel(ForwardAE), .reg_val(rd1_q), .wb_val(ResultW), .mem_val(ALUOutM), .y(fwd_a)
  );

  fwd_mux3 #(.W(data_size)) u_fwd_b (
    .sel(ForwardBE), .reg_val(rd2_q), .wb_val(ResultW), .mem_val(ALUOutM), .y(fwd_b)
  );

  // Operand, destination and control outputs
  always_comb begin
    SrcAE       = fwd_a;
    WriteDataE  = fwd_b;
    SrcBE       = ctrl_q.alu_src ? imm_q : fwd_b;
    WriteRegE   = ctrl_q.reg_dst ? rd_q : rt_q;
    ALUControlE = ctrl_q.alu_ctrl;
    RsE         = rs_q;
    RtE         = rt_q;
    RegWriteE   = ctrl_q.reg_write;
    MemtoRegE   = ctrl_q.mem_to_reg;
    MemWriteE   = ctrl_q.mem_write;
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] cnt_d, cnt_q;

  // Saturating count of bubble-insertion edges; stalls are ignored
  always_comb begin
    cnt_d = cnt_q;
    if (FlushE && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
  end

  // Counter register
  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign BubbleCountE = cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

  logic        CLK = 1'b0;
  logic        RST, StallE, FlushE;
  logic [31:0] RD1D, RD2D, SignImmD, ALUOutM, ResultW;
  logic [4:0]  RsD, RtD, RdD;
  logic [2:0]  ALUControlD;
  logic        ALUSrcD, RegDstD, RegWriteD, MemtoRegD, MemWriteD;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] SrcAE, SrcBE, WriteDataE;
  logic [2:0]  ALUControlE;
  logic [4:0]  WriteRegE, RsE, RtE;
  logic        RegWriteE, MemtoRegE, MemWriteE;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] BubbleCountE;
`endif

  int total = 0;
  int bad   = 0;

  id_ex_stage dut (
    .CLK(CLK), .RST(RST), .StallE(StallE), .FlushE(FlushE),
    .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
    .RsD(RsD), .RtD(RtD), .RdD(RdD), .ALUControlD(ALUControlD),
    .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .RegWriteD(RegWriteD),
    .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ALUOutM(ALUOutM), .ResultW(ResultW),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUControlE(ALUControlE),
    .WriteDataE(WriteDataE), .WriteRegE(WriteRegE), .RsE(RsE), .RtE(RtE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
`ifdef ID_EX_BUBBLE_CNT_EN
    .MemWriteE(MemWriteE), .BubbleCountE(BubbleCountE)
`else
    .MemWriteE(MemWriteE)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle before sampling
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; StallE = 1'b0; FlushE = 1'b0;
    RD1D = 32'h11; RD2D = 32'h22; SignImmD = 32'h33;
    RsD = 5'd1; RtD = 5'd2; RdD = 5'd3; ALUControlD = 3'b110;
    ALUSrcD = 1'b0; RegDstD = 1'b1; RegWriteD = 1'b1; MemtoRegD = 1'b1; MemWriteD = 1'b1;
    ForwardAE = 2'b00; ForwardBE = 2'b00; ALUOutM = 32'hAA; ResultW = 32'h55;

    // Reset with non-zero D inputs
    tick();
    chk("rst_srca", SrcAE, 32'h0);
    chk("rst_srcb", SrcBE, 32'h0);
    chk("rst_wdata", WriteDataE, 32'h0);
    chk("rst_wreg", {27'd0, WriteRegE}, 32'h0);
    chk("rst_rs", {27'd0, RsE}, 32'h0);
    chk("rst_rt", {27'd0, RtE}, 32'h0);
    chk("rst_ctl", {29'd0, RegWriteE, MemtoRegE, MemWriteE}, 32'h0);
    chk("rst_aluctl", {29'd0, ALUControlE}, 32'h2);

    // Basic load, one cycle latency
    RST = 1'b0;
    RD1D = 32'd5; RD2D = 32'd7; ALUControlD = 3'b100;
    RsD = 5'd6; RtD = 5'd8; RegDstD = 1'b0; MemWriteD = 1'b0;
    tick();
    chk("ld_srca", SrcAE, 32'd5);
    chk("ld_srcb", SrcBE, 32'd7);
    chk("ld_aluctl", {29'd0, ALUControlE}, 32'h4);
    chk("ld_rs", {27'd0, RsE}, 32'd6);
    chk("ld_rt", {27'd0, RtE}, 32'd8);
    chk("ld_wreg", {27'd0, WriteRegE}, 32'd8);
    chk("ld_ctl", {29'd0, RegWriteE, MemtoRegE, MemWriteE}, 32'h6);

    // Forwarding, combinational in the same cycle
    RD1D = 32'd1; RD2D = 32'd2;
    tick();
    ForwardAE = 2'b10; ForwardBE = 2'b01;
    #1;
    chk("fwd_a_mem", SrcAE, 32'hAA);
    chk("fwd_b_wb", SrcBE, 32'h55);
    chk("fwd_wdata_wb", WriteDataE, 32'h55);
    ForwardAE = 2'b01; ForwardBE = 2'b11;
    #1;
    chk("fwd_a_wb", SrcAE, 32'h55);
    chk("fwd_b_rsv", SrcBE, 32'd2);
    chk("fwd_wdata_rsv", WriteDataE, 32'd2);
    ALUOutM = 32'hBB;
    ForwardBE = 2'b10;
    #1;
    chk("fwd_b_mem_live", SrcBE, 32'hBB);
    ForwardAE = 2'b00; ForwardBE = 2'b00;
    #1;
    chk("fwd_a_reg", SrcAE, 32'd1);

    // Immediate and destination select
    ALUSrcD = 1'b1; SignImmD = 32'hFFFF_FFFC; RegDstD = 1'b1; RdD = 5'd9; RtD = 5'd4;
    tick();
    chk("imm_srcb", SrcBE, 32'hFFFF_FFFC);
    chk("imm_wdata", WriteDataE, 32'd2);
    chk("dst_rd", {27'd0, WriteRegE}, 32'd9);
    RegDstD = 1'b0;
    tick();
    chk("dst_rt", {27'd0, WriteRegE}, 32'd4);

    // Stall holds, then flush+stall loads a bubble
    ALUSrcD = 1'b0; RegWriteD = 1'b1; RD1D = 32'd3; ALUControlD = 3'b001;
    tick();
    chk("pre_stall_srca", SrcAE, 32'd3);
    StallE = 1'b1; RD1D = 32'd99; RegWriteD = 1'b0; ALUControlD = 3'b000;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_srca", SrcAE, 32'd3);
      chk("stall_regw", {31'd0, RegWriteE}, 32'd1);
      chk("stall_aluctl", {29'd0, ALUControlE}, 32'h1);
    end
    FlushE = 1'b1;
    tick();
    chk("flush_regw", {31'd0, RegWriteE}, 32'd0);
    chk("flush_srca", SrcAE, 32'd0);
    chk("flush_aluctl", {29'd0, ALUControlE}, 32'h2);

    // Reset during a stall still clears
    FlushE = 1'b0; StallE = 1'b0; RD1D = 32'd77; RegWriteD = 1'b1;
    tick();
    chk("reload_srca", SrcAE, 32'd77);
    StallE = 1'b1; RST = 1'b1;
    tick();
    chk("rst_stall_srca", SrcAE, 32'd0);
    chk("rst_stall_regw", {31'd0, RegWriteE}, 32'd0);
    StallE = 1'b0;

`ifdef ID_EX_BUBBLE_CNT_EN
    // Counter: cleared by the reset above, then 3 flushes, a stall, a reset
    chk("cnt_rst", BubbleCountE, 32'd0);
    RST = 1'b0; FlushE = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("cnt_flush", BubbleCountE, i);
    end
    FlushE = 1'b0; StallE = 1'b1;
    tick();
    chk("cnt_stall", BubbleCountE, 32'd3);
    StallE = 1'b0; RST = 1'b1; FlushE = 1'b1;
    tick();
    chk("cnt_rst_again", BubbleCountE, 32'd0);
    FlushE = 1'b0;
`endif

    RST = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
